// File: rtl/sync_fifo_ext.sv
// sync_fifo_ext: single-clock FIFO with arbitrary depth, show-ahead or registered read, level and error flags
module sync_fifo_ext #(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 5,
  parameter int FWFT          = 1,
  parameter int AFULL_THRESH  = DEPTH - 1,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                         iw_clk,
  input  logic                         iw_reset_n,
  input  logic                         iw_flush,
  input  logic [WIDTH-1:0]             iwv_wrdata,
  input  logic                         iw_wrena,
  input  logic                         iw_rdena,
  output logic [WIDTH-1:0]             owv_rddata,
  output logic                         ow_rdvalid,
  output logic                         ow_full,
  output logic                         ow_empty,
  output logic                         ow_afull,
  output logic                         ow_aempty,
  output logic [$clog2(DEPTH+1)-1:0]   owv_level,
  output logic                         ow_overflow,
  output logic                         ow_underflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_AF   = LW'(AFULL_THRESH);
  localparam logic [LW-1:0] LVL_AE   = LW'(AEMPTY_THRESH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             wr_acc, rd_acc;

  assign ow_full      = level_q == LVL_FULL;
  assign ow_empty     = level_q == '0;
  assign ow_afull     = level_q >= LVL_AF;
  assign ow_aempty    = level_q <= LVL_AE;
  assign owv_level    = level_q;
  assign ow_overflow  = ovf_q;
  assign ow_underflow = unf_q;

  assign wr_acc = iw_wrena & ~ow_full & ~iw_flush;
  assign rd_acc = iw_rdena & ~ow_empty & ~iw_flush;

  // next-state for pointers, level and sticky errors; flush wins over everything
  always_comb begin
    wr_ptr_d = iw_flush ? '0 : wr_acc ? ((wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d = iw_flush ? '0 : rd_acc ? ((rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1)) : rd_ptr_q;
    level_d  = iw_flush ? '0 : (wr_acc & ~rd_acc) ? level_q + LW'(1) :
               (rd_acc & ~wr_acc) ? level_q - LW'(1) : level_q;
    ovf_d    = ~iw_flush & (ovf_q | (iw_wrena & ow_full));
    unf_d    = ~iw_flush & (unf_q | (iw_rdena & ow_empty));
  end

  // control state registers
  always_ff @(posedge iw_clk or negedge iw_reset_n)
    if (!iw_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end

  // storage array, not reset, written only on an accepted write
  always_ff @(posedge iw_clk)
    if (wr_acc) mem_q[wr_ptr_q] <= iwv_wrdata;

  if (FWFT != 0) begin : g_fwft
    assign owv_rddata = mem_q[rd_ptr_q];
    assign ow_rdvalid = ~ow_empty;
  end else begin : g_reg
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             rdvalid_q;
    assign rdata_d    = rd_acc ? mem_q[rd_ptr_q] : rdata_q;
    assign owv_rddata = rdata_q;
    assign ow_rdvalid = rdvalid_q;
    // output register loads the head on an accepted read and pulses valid for one cycle
    always_ff @(posedge iw_clk or negedge iw_reset_n)
      if (!iw_reset_n) begin
        rdata_q   <= '0;
        rdvalid_q <= 1'b0;
      end else begin
        rdata_q   <= rdata_d;
        rdvalid_q <= rd_acc;
      end
  end
endmodule

// File: tb/tb_sync_fifo_ext.sv
// tb_sync_fifo_ext: scoreboard bench driving a show-ahead and a registered-read FIFO with shared stimulus
module tb_sync_fifo_ext;
  logic       clk = 1'b0;
  logic       rst_n, flush, wr, rd;
  logic [7:0] wd;
  logic [7:0] rdata1, rdata0;
  logic       v1, full1, empty1, af1, ae1, ovf1, unf1;
  logic       v0, full0, empty0, af0, ae0, ovf0, unf0;
  logic [2:0] lvl1, lvl0;
  logic [9:0] st1, st0;
  logic [7:0] q1[$], q0[$];
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  sync_fifo_ext #(.WIDTH(8), .DEPTH(5), .FWFT(1), .AFULL_THRESH(4), .AEMPTY_THRESH(1)) d1 (
    .iw_clk(clk), .iw_reset_n(rst_n), .iw_flush(flush), .iwv_wrdata(wd), .iw_wrena(wr), .iw_rdena(rd),
    .owv_rddata(rdata1), .ow_rdvalid(v1), .ow_full(full1), .ow_empty(empty1), .ow_afull(af1),
    .ow_aempty(ae1), .owv_level(lvl1), .ow_overflow(ovf1), .ow_underflow(unf1));

  sync_fifo_ext #(.WIDTH(8), .DEPTH(5), .FWFT(0), .AFULL_THRESH(4), .AEMPTY_THRESH(1)) d0 (
    .iw_clk(clk), .iw_reset_n(rst_n), .iw_flush(flush), .iwv_wrdata(wd), .iw_wrena(wr), .iw_rdena(rd),
    .owv_rddata(rdata0), .ow_rdvalid(v0), .ow_full(full0), .ow_empty(empty0), .ow_afull(af0),
    .ow_aempty(ae0), .owv_level(lvl0), .ow_overflow(ovf0), .ow_underflow(unf0));

  assign st1 = {v1, ovf1, unf1, full1, empty1, af1, ae1, lvl1};
  assign st0 = {1'b0, ovf0, unf0, full0, empty0, af0, ae0, lvl0};

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", n, a, e);
    end
  endtask

  task automatic chk_st(string n, int lvl, bit o, bit u);
    logic [9:0] e;
    e = {lvl != 0, o, u, lvl == 5, lvl == 0, lvl >= 4, lvl <= 1, 3'(lvl)};
    chk({n, "/fwft"}, 32'(st1), 32'(e));
    chk({n, "/reg"}, 32'(st0), 32'({1'b0, e[8:0]}));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(logic [7:0] v);
    q1.push_back(v);
    q0.push_back(v);
  endtask

  // show-ahead monitor: an accepted read consumes the word visible before the edge
  always @(negedge clk) begin : mon1
    logic [7:0] e;
    if (rd && v1 && !flush) begin
      checks++;
      if (q1.size() == 0) begin
        failures++;
        $display("FAIL mon_fwft unexpected read act=%0h exp=none", rdata1);
      end else begin
        e = q1.pop_front();
        if (rdata1 !== e) begin
          failures++;
          $display("FAIL mon_fwft act=%0h exp=%0h", rdata1, e);
        end
      end
    end
  end

  // registered-read monitor: every valid pulse must match the next expected word
  always @(negedge clk) begin : mon0
    logic [7:0] e;
    if (v0) begin
      checks++;
      if (q0.size() == 0) begin
        failures++;
        $display("FAIL mon_reg unexpected pulse act=%0h exp=none", rdata0);
      end else begin
        e = q0.pop_front();
        if (rdata0 !== e) begin
          failures++;
          $display("FAIL mon_reg act=%0h exp=%0h", rdata0, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; wr = 1'b0; rd = 1'b0; wd = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk_st("reset", 0, 0, 0);
    chk("reset_rdata0", 32'(rdata0), 0);
    chk("reset_v0", 32'(v0), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr = 1'b1; wd = 8'(17 * (i + 1));
      tick();
      chk_st($sformatf("fill%0d", i + 1), i + 1, 0, 0);
      chk("fill_head", 32'(rdata1), 32'h11);
    end
    wd = 8'h66; rd = 1'b1; push(8'h11);
    tick();
    wr = 1'b0; rd = 1'b0;
    chk_st("full_rw", 4, 1, 0);
    chk("full_rw_head", 32'(rdata1), 32'h22);
    chk("full_rw_v0", 32'(v0), 1);
    chk("full_rw_d0", 32'(rdata0), 32'h11);
    for (int i = 0; i < 4; i++) begin
      rd = 1'b1; push(8'(17 * (i + 2)));
      tick();
      chk_st($sformatf("drain%0d", i), 3 - i, 1, 0);
    end
    rd = 1'b0;
    wr = 1'b1; wd = 8'h80;
    tick();
    chk_st("prefill", 1, 1, 0);
    for (int i = 0; i < 13; i++) begin
      wr = 1'b1; rd = 1'b1; wd = 8'(8'h81 + i); push(8'(8'h80 + i));
      tick();
      chk_st($sformatf("pair%0d", i), 1, 1, 0);
    end
    wr = 1'b0; rd = 1'b1; push(8'h8D);
    tick();
    rd = 1'b0;
    chk_st("wrap_drain", 0, 1, 0);
    wr = 1'b1; wd = 8'hA5;
    tick();
    wd = 8'h5A;
    tick();
    wr = 1'b0;
    chk_st("ab", 2, 1, 0);
    rd = 1'b1; push(8'hA5);
    tick();
    rd = 1'b0;
    chk("rv_pulse", 32'(v0), 1);
    chk("rv_data", 32'(rdata0), 32'hA5);
    tick();
    chk("rv_after", 32'(v0), 0);
    chk("rv_hold", 32'(rdata0), 32'hA5);
    chk_st("ab1", 1, 1, 0);
    rd = 1'b1; push(8'h5A);
    tick();
    rd = 1'b0;
    tick();
    chk_st("ab0", 0, 1, 0);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    chk("unf_nopulse", 32'(v0), 0);
    chk_st("unf", 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      wr = 1'b1; wd = 8'(8'hC1 + i);
      tick();
    end
    wr = 1'b0;
    chk_st("pre_flush", 3, 1, 1);
    flush = 1'b1; wr = 1'b1; wd = 8'hEE; rd = 1'b1;
    tick();
    flush = 1'b0; wr = 1'b0; rd = 1'b0;
    chk_st("flush", 0, 0, 0);
    chk("flush_v0", 32'(v0), 0);
    chk("flush_hold", 32'(rdata0), 32'h5A);
    wr = 1'b1; wd = 8'h77;
    tick();
    wr = 1'b0;
    chk("post_flush_head", 32'(rdata1), 32'h77);
    rd = 1'b1; push(8'h77);
    tick();
    rd = 1'b0;
    chk_st("post_flush", 0, 0, 0);
    rd = 1'b1;
    tick();
    rd = 1'b0; wr = 1'b1; wd = 8'h31;
    tick();
    wd = 8'h32;
    tick();
    wr = 1'b0;
    chk_st("pre_rst", 2, 0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk_st("async_rst", 0, 0, 0);
    chk("async_rst_v0", 32'(v0), 0);
    chk("async_rst_d0", 32'(rdata0), 0);
    #2 rst_n = 1'b1;
    tick();
    wr = 1'b1; wd = 8'h44;
    tick();
    wd = 8'h45;
    tick();
    wr = 1'b0;
    chk("rst_head", 32'(rdata1), 32'h44);
    rd = 1'b1; push(8'h44);
    tick();
    push(8'h45);
    tick();
    rd = 1'b0;
    tick();
    chk_st("final", 0, 0, 0);
    chk("q1_drained", 32'(q1.size()), 0);
    chk("q0_drained", 32'(q0.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sync_fifo_ext.md
Name: sync_fifo_ext

Overview:
Parametrised single-clock FIFO. It is the synchronous successor of the team's dual-clock FIFO for blocks that live in one clock domain. Depth is arbitrary, not limited to a power of two. Adds a selectable read mode (show-ahead or registered), a fill-level output, programmable almost-full and almost-empty flags, synchronous flush, and sticky overflow/underflow error flags.

Parameters:
WIDTH, 8, data bus width; must be >= 1
DEPTH, 5, number of storage entries; must be >= 2; any integer, not only powers of two
FWFT, 1, read mode: 1 = show-ahead (head word visible on owv_rddata), 0 = registered read (data one cycle after an accepted read)
AFULL_THRESH, DEPTH-1, ow_afull asserts when level >= this value; range 1..DEPTH
AEMPTY_THRESH, 1, ow_aempty asserts when level <= this value; range 0..DEPTH-1

Ports:
iw_clk  in  1  clock; all state updates on the rising edge
iw_reset_n  in  1  asynchronous active-low reset; deassertion is synchronous to iw_clk and is the integrator's responsibility
iw_flush  in  1  synchronous clear of contents
iwv_wrdata  in  WIDTH  write data
iw_wrena  in  1  write request
iw_rdena  in  1  read request (pop)
owv_rddata  out  WIDTH  read data
ow_rdvalid  out  1  FWFT=1: equals ~ow_empty; FWFT=0: one-cycle pulse, owv_rddata valid
ow_full  out  1  level == DEPTH
ow_empty  out  1  level == 0
ow_afull  out  1  level >= AFULL_THRESH
ow_aempty  out  1  level <= AEMPTY_THRESH
owv_level  out  $clog2(DEPTH+1)  current number of stored words
ow_overflow  out  1  sticky: a write was attempted while full
ow_underflow  out  1  sticky: a read was attempted while empty

Behaviour:
- Reset (iw_reset_n=0, asynchronous) forces the following state immediately:
  - write pointer, read pointer and level = 0
  - ow_empty=1, ow_full=0, ow_aempty=1; ow_afull=0 (AFULL_THRESH >= 1)
  - ow_overflow=0, ow_underflow=0
  - FWFT=0: output data register = 0 and ow_rdvalid = 0
  - Memory contents are not reset.
- Write accepted iff iw_wrena & ~ow_full. The word is stored at the write pointer. The write pointer advances; it wraps from DEPTH-1 to 0 with explicit compare, never by modulo 2^n.
- Read accepted iff iw_rdena & ~ow_empty. The read pointer advances with the same wrap rule.
- No write-through and no simultaneous pass-through:
  - When full, a write is rejected even if a read is accepted in the same cycle.
  - When empty, a read is rejected even if a write is accepted in the same cycle.
- Level update per cycle:
  - +1 for a write alone
  - -1 for a read alone
  - unchanged for both or neither
  - never leaves 0..DEPTH
- All status flags are derived from the registered level. They reflect an accepted operation in the cycle after the edge on which it was accepted.
- FWFT=1:
  - owv_rddata = mem[rd_ptr], combinational from the registered pointer.
  - Content is don't-care while empty. The bench must not check owv_rddata when ow_rdvalid=0.
- FWFT=0:
  - On an accepted read, mem[rd_ptr] is loaded into the output register.
  - ow_rdvalid=1 for exactly the following cycle.
  - owv_rddata holds its last value otherwise.
  - Rejected reads do not pulse ow_rdvalid.
- Errors:
  - ow_overflow sets on iw_wrena & ow_full.
  - ow_underflow sets on iw_rdena & ow_empty.
  - Both hold until reset or flush.
  - A rejected request has no other effect.
- Flush:
  - iw_flush=1 takes priority over any read or write in the same cycle; those requests are ignored and do not set the error flags.
  - Next cycle: pointers = 0, level = 0, errors cleared, ow_rdvalid = 0.
  - The FWFT=0 data register keeps its value.
- Storage: plain register array (DEPTH x WIDTH), written only on an accepted write.

Test Plan:
- WIDTH=8, DEPTH=5, FWFT=1: after reset, write 0x11,0x22,0x33,0x44,0x55 on 5 consecutive cycles -> level counts 1..5; ow_full=1 after the 5th edge; ow_afull=1 from level 4; owv_rddata=0x11 from the cycle after the first write.
- Same config, full; assert wrena with 0x66 and rdena together for one cycle -> read accepted, write rejected, ow_overflow=1, level=4, owv_rddata=0x22. Drain 4 -> data 0x22..0x55, ow_empty=1, ow_aempty=1 at level<=1.
- DEPTH=5: run 13 write/read pairs, with one word pre-filled so the FIFO stays non-empty, and pointers crossing 4->0 twice -> data order preserved with no loss; level constant at 1.
- FWFT=0: write 0xA5, 0x5A; read on one cycle -> ow_rdvalid pulses 1 cycle later with owv_rddata=0xA5, then holds 0xA5 while ow_rdvalid=0. Read when empty -> no pulse, ow_underflow=1.
- Level 3 with ow_overflow=1; assert iw_flush together with wrena and rdena -> next cycle level=0, ow_empty=1, ow_overflow=0, ow_underflow=0; written word absent on subsequent reads.
- Assert iw_reset_n=0 mid-cycle at level 2 without a clock edge -> ow_empty=1, owv_level=0 and error flags 0 immediately; after release, first written word is the first read.
